// File: rtl/conv3x3_pkg.sv
// Shared widths, default kernel and output saturation for the 3x3 convolution filter.
// Loadable-kernel build is selected with CONV3X3_KERNEL_LOAD_EN (see conv3x3_kernel_regs).
package conv3x3_pkg;

   localparam int PIX_W  = 8;
   localparam int COEF_W = 8;
   localparam int PROD_W = 17;
   localparam int ROW_W  = 19;
   localparam int SUM_W  = 21;
   localparam int NTAPS  = 9;
   localparam int KERN_W = NTAPS * COEF_W;

   // Byte k holds element k (row k/3, col k%3); the default kernel sums to 16.
   localparam logic [KERN_W-1:0] DEFAULT_KERNEL = {
      8'sd1, 8'sd2, 8'sd1,
      8'sd2, 8'sd4, 8'sd2,
      8'sd1, 8'sd2, 8'sd1
   };

   function automatic logic [PIX_W-1:0] sat_u8(input logic signed [SUM_W-1:0] v);
      logic [PIX_W-1:0] r;
      if (v < 21'sd0) begin
         r = 8'd0;
      end else if (v > 21'sd255) begin
         r = 8'd255;
      end else begin
         r = v[PIX_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/conv3x3_kernel_regs.sv
// Coefficient storage: shadow/active banks with an idle-gated commit when
// CONV3X3_KERNEL_LOAD_EN is defined, otherwise a constant default kernel.
module conv3x3_kernel_regs
   import conv3x3_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_wr_en,
   input  logic [3:0]        i_wr_addr,
   input  logic [COEF_W-1:0] i_wr_data,
   input  logic              i_commit,
   input  logic              i_idle,
   output logic [KERN_W-1:0] o_kernel,
   output logic              o_pending
);

`ifdef CONV3X3_KERNEL_LOAD_EN
   logic [KERN_W-1:0] r_shadow;
   logic [KERN_W-1:0] r_active;
   logic              r_pending;

   // Swap only when nothing is in flight so no window ever sees a mixed kernel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow  <= DEFAULT_KERNEL;
         r_active  <= DEFAULT_KERNEL;
         r_pending <= 1'b0;
      end else begin
         if (i_wr_en && (i_wr_addr < 4'd9)) begin
            r_shadow[i_wr_addr*COEF_W +: COEF_W] <= i_wr_data;
         end
         if (r_pending && i_idle) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
         end else if (i_commit) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign o_kernel  = r_active;
   assign o_pending = r_pending;
`else
   logic w_unused;

   assign w_unused  = ^{clk, reset_n, i_wr_en, i_wr_addr, i_wr_data, i_commit, i_idle};
   assign o_kernel  = DEFAULT_KERNEL;
   assign o_pending = 1'b0;
`endif

endmodule

// File: rtl/conv3x3_filter.sv
// 4-stage 3x3 signed convolution with rounding, shift, saturation and a per-line done pulse.
// Runtime kernel loading is enabled by defining CONV3X3_KERNEL_LOAD_EN.
module conv3x3_filter
   import conv3x3_pkg::*;
#(
   parameter int IMAGE_WIDTH = 512,
   parameter int SHIFT       = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NTAPS*PIX_W-1:0]  i_pixel_data,
   input  logic                    i_pixel_data_valid,
   input  logic                    i_kernel_wr_en,
   input  logic [3:0]              i_kernel_wr_addr,
   input  logic [COEF_W-1:0]       i_kernel_wr_data,
   input  logic                    i_kernel_commit,
   output logic [PIX_W-1:0]        o_conv_data,
   output logic                    o_conv_data_valid,
   output logic                    o_line_done,
   output logic                    o_kernel_pending
);

   localparam int CNT_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMAGE_WIDTH - 1);
   localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
   localparam logic signed [SUM_W-1:0] ROUND = (SHIFT > 0) ? (21'sd1 <<< RND_SH) : 21'sd0;

   logic [KERN_W-1:0]        w_kernel;
   logic                     w_idle;
   logic signed [PROD_W-1:0] w_prod [NTAPS];
   logic signed [SUM_W-1:0]  w_shifted;

   logic signed [PROD_W-1:0] r_prod [NTAPS];
   logic signed [ROW_W-1:0]  r_row  [3];
   logic signed [SUM_W-1:0]  r_total;
   logic                     r_v1;
   logic                     r_v2;
   logic                     r_v3;
   logic [CNT_W-1:0]         r_cnt;

   assign w_idle = !i_pixel_data_valid && !r_v1 && !r_v2 && !r_v3 && !o_conv_data_valid;

   conv3x3_kernel_regs u_kernel_regs (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (i_kernel_wr_en),
      .i_wr_addr (i_kernel_wr_addr),
      .i_wr_data (i_kernel_wr_data),
      .i_commit  (i_kernel_commit),
      .i_idle    (w_idle),
      .o_kernel  (w_kernel),
      .o_pending (o_kernel_pending)
   );

   // Pixels are unsigned, so a zero MSB makes them non-negative signed operands.
   always_comb begin
      for (int k = 0; k < NTAPS; k++) begin
         w_prod[k] = PROD_W'($signed({1'b0, i_pixel_data[k*PIX_W +: PIX_W]}))
                   * PROD_W'($signed(w_kernel[k*COEF_W +: COEF_W]));
      end
   end

   assign w_shifted = r_total >>> SHIFT;

   // Datapath and valid shift register, stages S1..S4.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAPS; k++) begin
            r_prod[k] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            r_row[r] <= '0;
         end
         r_total           <= '0;
         r_v1              <= 1'b0;
         r_v2              <= 1'b0;
         r_v3              <= 1'b0;
         o_conv_data_valid <= 1'b0;
         o_conv_data       <= 8'd0;
      end else begin
         for (int k = 0; k < NTAPS; k++) begin
            r_prod[k] <= w_prod[k];
         end
         for (int r = 0; r < 3; r++) begin
            r_row[r] <= ROW_W'(r_prod[3*r]) + ROW_W'(r_prod[3*r+1]) + ROW_W'(r_prod[3*r+2]);
         end
         r_total <= SUM_W'(r_row[0]) + SUM_W'(r_row[1]) + SUM_W'(r_row[2]) + ROUND;
         r_v1              <= i_pixel_data_valid;
         r_v2              <= r_v1;
         r_v3              <= r_v2;
         o_conv_data_valid <= r_v3;
         if (r_v3) begin
            o_conv_data <= sat_u8(w_shifted);
         end
      end
   end

   // Output pixel counter; the done pulse rides with the last output of each line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         o_line_done <= 1'b0;
      end else begin
         o_line_done <= 1'b0;
         if (r_v3) begin
            if (r_cnt == CNT_MAX) begin
               r_cnt       <= '0;
               o_line_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule
